ro_meas_sched: RTL and testbench

- Measurement scheduler for a bank of ring-oscillator delay paths (inverter chains closed into loops by an enable).
- Enables one oscillator at a time, following a request mask. Discards a settle window, then counts the selected oscillator's rising edges over a fixed gate window of system clocks.
- Reports each count with a valid/ready handshake.
- Sits between the host/capture logic and the delay-path instances. It is the only driver of their enables.

---
 rtl/ro_meas_pkg.sv | 34 +++
 rtl/ro_edge_sync.sv | 27 ++
 rtl/ro_meas_sched.sv | 156 +++++++++++++++
 tb/tb_ro_meas_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// rtl/ro_meas_pkg.sv - shared types, defaults and index search for the ring-oscillator scheduler
package ro_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_REPORT
    } state_t;

    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_GATE_CYCLES   = 1024;
    localparam int DEF_CNT_W         = 16;
    localparam int MAX_RO            = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Lowest set bit of mask whose index is >= from; found=0 when none remain.
    function automatic pick_t find_from(input logic [MAX_RO-1:0] mask, input int from);
        pick_t p;
        p = '0;
        for (int i = MAX_RO - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                p.found = 1'b1;
                p.idx   = 4'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// rtl/ro_edge_sync.sv - two-flop synchronizer followed by a registered rising-edge detector
module ro_edge_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ro_meas_sched.sv
// rtl/ro_meas_sched.sv - one-at-a-time ring-oscillator enable, settle, gated edge count and result handshake
module ro_meas_sched
    import ro_meas_pkg::*;
#(
    parameter int NUM_RO        = 4,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int IDX_W         = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_cont,
    input  logic [NUM_RO-1:0] i_ro_mask,
    input  logic [NUM_RO-1:0] i_ro_out,
    output logic [NUM_RO-1:0] o_ro_en,
    output logic              o_busy,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [IDX_W-1:0]  o_res_idx,
    output logic [CNT_W-1:0]  o_res_count,
    output logic              o_res_ovf,
    output logic              o_done
);

    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    state_t              r_state;
    logic [NUM_RO-1:0]   r_mask;
    logic [NUM_RO-1:0]   r_ro_en;
    logic                r_cont;
    logic                r_busy;
    logic                r_valid;
    logic                r_done;
    logic                r_ovf;
    logic [IDX_W-1:0]    r_idx;
    logic [TMR_W-1:0]    r_tmr;
    logic [CNT_W-1:0]    r_edge_cnt;
    pick_t               w_pick;
    logic                w_go;
    logic                w_rise;

    // Next oscillator: from the fresh mask in IDLE, otherwise above the current index, wrapping only in continuous mode.
    always_comb begin
        w_pick = '0;
        if (r_state == ST_IDLE) begin
            w_pick = find_from(MAX_RO'(i_ro_mask), 0);
        end else begin
            w_pick = find_from(MAX_RO'(r_mask), int'(r_idx) + 1);
            if (!w_pick.found && r_cont) begin
                w_pick = find_from(MAX_RO'(r_mask), 0);
            end
        end
    end

    assign w_go = w_pick.found &&
                  ((r_state == ST_IDLE && i_start) || (r_state == ST_REPORT && i_res_ready));

    ro_edge_sync u_edge_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_ro_out[r_idx]),
        .o_rise  (w_rise)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_mask     <= '0;
            r_ro_en    <= '0;
            r_cont     <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_idx      <= '0;
            r_tmr      <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_stop) begin
                r_state <= ST_IDLE;
                r_ro_en <= '0;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
            end else if (w_go) begin
                if (r_state == ST_IDLE) begin
                    r_mask <= i_ro_mask;
                    r_cont <= i_cont;
                end
                r_state    <= ST_SETTLE;
                r_idx      <= IDX_W'(w_pick.idx);
                r_ro_en    <= NUM_RO'(1) << w_pick.idx;
                r_tmr      <= '0;
                r_edge_cnt <= '0;
                r_ovf      <= 1'b0;
                r_busy     <= 1'b1;
                r_valid    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_done <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                            r_state <= ST_GATE;
                            r_tmr   <= '0;
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end
                    ST_GATE: begin
                        if (w_rise) begin
                            if (&r_edge_cnt) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_edge_cnt <= r_edge_cnt + 1'b1;
                            end
                        end
                        if (r_tmr == TMR_W'(GATE_CYCLES - 1)) begin
                            r_state <= ST_REPORT;
                            r_ro_en <= '0;
                            r_valid <= 1'b1;
                            r_tmr   <= '0;
                        end else begin
                            r_tmr <= r_tmr + 1'b1;
                        end
                    end
                    ST_REPORT: begin
                        if (i_res_ready) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_ro_en     = r_ro_en;
    assign o_busy      = r_busy;
    assign o_res_valid = r_valid;
    assign o_res_idx   = r_idx;
    assign o_res_count = r_edge_cnt;
    assign o_res_ovf   = r_ovf;
    assign o_done      = r_done;

endmodule

// File: tb/tb_ro_meas_sched.sv
// tb/tb_ro_meas_sched.sv - randomized bench with a cycle-timeline reference model for ro_meas_sched
module tb_ro_meas_sched;

    localparam int NUM_RO  = 4;
    localparam int SETTLE  = 8;
    localparam int GATE    = 100;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              cont = 1'b0;
    logic              res_ready = 1'b1;
    logic [NUM_RO-1:0] ro_mask = '0;
    logic [NUM_RO-1:0] ro_out = '0;
    logic [NUM_RO-1:0] ro_en;
    logic              busy;
    logic              res_valid;
    logic [IDX_W-1:0]  res_idx;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;
    logic              done;

    ro_meas_sched #(
        .NUM_RO(NUM_RO), .SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_cont(cont),
        .i_ro_mask(ro_mask), .i_ro_out(ro_out), .o_ro_en(ro_en), .o_busy(busy),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_idx(res_idx),
        .o_res_count(res_count), .o_res_ovf(res_ovf), .o_done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int half [NUM_RO];
    int ph   [NUM_RO];
    logic [NUM_RO-1:0] hist [65536];

    typedef struct {
        int idx;
        int cnt;
        int ovf;
    } res_t;
    res_t res_q[$];
    int   n_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lowest(input logic [NUM_RO-1:0] m, input int from);
        for (int i = from; i < NUM_RO; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic hbit(input int c, input int i);
        logic [NUM_RO-1:0] v;
        v = hist[c[15:0]];
        return v[i];
    endfunction

    // Oscillators run only while enabled, square wave of 2*half[i] clocks starting low.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        for (int i = 0; i < NUM_RO; i++) begin
            if (ro_en[i]) begin
                ro_out[i] = ((ph[i] / half[i]) % 2) == 1;
                ph[i]++;
            end else begin
                ro_out[i] = 1'b0;
                ph[i] = 0;
            end
        end
        hist[cyc[15:0]] = ro_out;
    end

    int   m_busy = 0, m_done = 0, m_idx = 0, m_t0 = 0, m_cont = 0, m_nxt, g0, g1, nexp;
    logic [NUM_RO-1:0] m_mask = '0;
    logic valid_e;

    // Timeline model: a measurement begun at cycle t0 settles t0+1..t0+S, gates t0+S+1..t0+S+G, reports after.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {ro_en, busy, res_valid, res_idx, res_count, res_ovf, done}, 0);
            m_busy = 0;
            m_done = 0;
        end else begin
            g0 = m_t0 + 1 + SETTLE;
            g1 = m_t0 + SETTLE + GATE;
            valid_e = (m_busy != 0) && (cyc > g1);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("ro_en", ro_en, ((m_busy != 0) && cyc <= g1) ? (1 << m_idx) : 0);
            check("res_valid", res_valid, valid_e);
            if (valid_e) begin
                nexp = 0;
                for (int c = g0 - 2; c <= g1 - 2; c++)
                    if (hbit(c, m_idx) && !hbit(c - 1, m_idx)) nexp++;
                check("res_idx", res_idx, m_idx);
                check("res_count", res_count, (nexp > CNT_MAX) ? CNT_MAX : nexp);
                check("res_ovf", res_ovf, nexp > CNT_MAX);
            end
            if (done) n_done++;
            m_done = 0;
            if (stop) begin
                m_busy = 0;
            end else if (m_busy == 0) begin
                if (start) begin
                    if (ro_mask == 0) m_done = 1;
                    else begin
                        m_mask = ro_mask;
                        m_cont = cont;
                        m_idx  = lowest(ro_mask, 0);
                        m_t0   = cyc;
                        m_busy = 1;
                    end
                end
            end else if (valid_e && res_ready) begin
                res_q.push_back('{int'(res_idx), int'(res_count), int'(res_ovf)});
                m_nxt = lowest(m_mask, m_idx + 1);
                if (m_nxt < 0 && m_cont != 0) m_nxt = lowest(m_mask, 0);
                if (m_nxt >= 0) begin
                    m_idx = m_nxt;
                    m_t0  = cyc;
                end else begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_start(input logic [NUM_RO-1:0] m, input logic c);
        tick(1);
        ro_mask = m;
        cont    = c;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input bit rnd_ready, input int stop_at);
        int k;
        k = 0;
        while (busy && k < limit) begin
            if (rnd_ready) res_ready = ($urandom_range(0, 2) != 0);
            stop = (k == stop_at);
            tick(1);
            k++;
        end
        stop = 1'b0;
        res_ready = 1'b1;
        check("wait_idle_in_time", k < limit, 1);
        tick(3);
    endtask

    task automatic wait_valid(input int limit);
        int k;
        k = 0;
        while (!res_valid && k < limit) begin
            tick(1);
            k++;
        end
        check("wait_valid_in_time", k < limit, 1);
    endtask

    initial begin
        for (int i = 0; i < NUM_RO; i++) begin
            half[i] = 5;
            ph[i] = 0;
        end
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // basic count
        res_q.delete(); n_done = 0;
        do_start(4'b0001, 1'b0);
        wait_idle(400, 0, -1);
        check("basic_nres", res_q.size(), 1);
        if (res_q.size() == 1) begin
            check("basic_idx", res_q[0].idx, 0);
            check("basic_cnt", res_q[0].cnt, 10);
            check("basic_ovf", res_q[0].ovf, 0);
        end
        check("basic_done", n_done, 1);

        // sparse mask
        res_q.delete(); n_done = 0;
        half[1] = 5; half[3] = 10;
        do_start(4'b1010, 1'b0);
        wait_idle(600, 0, -1);
        check("sparse_nres", res_q.size(), 2);
        if (res_q.size() == 2) begin
            check("sparse_idx0", res_q[0].idx, 1);
            check("sparse_cnt0", res_q[0].cnt, 10);
            check("sparse_idx1", res_q[1].idx, 3);
            check("sparse_cnt1", res_q[1].cnt, 5);
        end
        check("sparse_done", n_done, 1);

        // saturation
        res_q.delete();
        half[0] = 2;
        do_start(4'b0001, 1'b0);
        wait_idle(400, 0, -1);
        check("sat_nres", res_q.size(), 1);
        if (res_q.size() == 1) begin
            check("sat_cnt", res_q[0].cnt, 15);
            check("sat_ovf", res_q[0].ovf, 1);
        end

        // backpressure
        half[0] = 4; half[1] = 3;
        res_ready = 1'b0;
        do_start(4'b0011, 1'b0);
        wait_valid(400);
        tick(50);
        check("bp_valid_held", res_valid, 1);
        check("bp_ro_en_off", ro_en, 0);
        res_ready = 1'b1;
        tick(1);
        check("bp_next_settle", ro_en, 4'b0010);
        wait_idle(400, 0, -1);

        // continuous mode, ignored start while busy, then stop mid-gate
        res_q.delete(); n_done = 0;
        do_start(4'b0011, 1'b1);
        tick(20);
        ro_mask = 4'b1100; cont = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(480);
        check("cont_nres_ge4", res_q.size() >= 4, 1);
        if (res_q.size() >= 4) begin
            check("cont_seq0", res_q[0].idx, 0);
            check("cont_seq1", res_q[1].idx, 1);
            check("cont_seq2", res_q[2].idx, 0);
            check("cont_seq3", res_q[3].idx, 1);
        end
        wait_valid(400);
        tick(1);
        tick(SETTLE + 30);
        begin
            int nr;
            nr = res_q.size();
            stop = 1'b1;
            tick(1);
            stop = 1'b0;
            check("stop_ro_en", ro_en, 0);
            check("stop_busy", busy, 0);
            tick(GATE);
            check("stop_no_result", res_q.size(), nr);
            check("stop_no_done", n_done, 0);
        end

        // empty mask, and stop+start together
        do_start(4'b0000, 1'b0);
        check("zero_mask_done", done, 1);
        stop = 1'b1;
        do_start(4'b0101, 1'b0);
        stop = 1'b0;
        check("stop_beats_start", busy, 0);
        tick(3);

        // asynchronous reset during gate
        half[2] = 3;
        do_start(4'b0100, 1'b0);
        tick(SETTLE + 20);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset_outs", {ro_en, busy, res_valid, res_count, done}, 0);
        tick(3);
        rst_n = 1'b1;
        res_q.delete();
        half[0] = 5;
        do_start(4'b0001, 1'b0);
        wait_idle(400, 0, -1);
        check("post_reset_nres", res_q.size(), 1);
        if (res_q.size() == 1) check("post_reset_cnt", res_q[0].cnt, 10);

        // randomized scans checked by the timeline model
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NUM_RO; i++) half[i] = $urandom_range(2, 12);
            do_start(4'($urandom_range(1, 15)), 1'b0);
            wait_idle(2000, 1, (it % 4 == 3) ? int'($urandom_range(0, 300)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
